ctrl_fsm: RTL and testbench

- Multicycle RV32IM control unit: the issuing side of the ALU's alu_ctrl/zero interface.
- Decodes the instruction register and sequences fetch, decode, execute, memory and writeback one step per state.
- Drives datapath muxes, write enables, the memory request handshake and the 4-bit ALU opcode.
- Consumes the ALU zero flag to resolve branches.

---
 rtl/ctrl_fsm.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_ctrl_fsm.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multicycle RV32IM control unit.
// Decodes the instruction register and sequences fetch/decode/execute/
// memory/writeback, one step per state. Drives datapath mux selects, write
// enables, the memory request handshake and the 4-bit ALU opcode; consumes
// the ALU zero flag to resolve branches.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   instr[31:0]         instruction register contents
//   zero                ALU zero flag
//   mem_ready           memory accepts/completes the request this cycle
//   mem_req, mem_we     memory request / request is a store
//   adr_src             memory address: 0 PC, 1 ALUOut
//   ir_write, pc_write  IR/old_pc latch, PC update
//   reg_write           register file write of rd
//   alu_src_a/b         ALU operand selects
//   imm_src             immediate format (from instr[6:0])
//   result_src          result bus select
//   alu_ctrl            ALU opcode
//   retire              instruction completes this cycle
//   trap                illegal instruction seen (held until reset)
module ctrl_fsm #(
    parameter bit M_EXT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  imm_src,
    output logic [1:0]  result_src,
    output logic [3:0]  alu_ctrl,
    output logic        retire,
    output logic        trap
);

    localparam int unsigned ALU_W = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(4'h0);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(4'h1);
    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(4'h2);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(4'h3);
    localparam logic [ALU_W-1:0] ALU_XOR = ALU_W'(4'h4);
    localparam logic [ALU_W-1:0] ALU_SLL = ALU_W'(4'h5);
    localparam logic [ALU_W-1:0] ALU_SRA = ALU_W'(4'h6);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(4'h7);
    localparam logic [ALU_W-1:0] ALU_EQ  = ALU_W'(4'h8);
    localparam logic [ALU_W-1:0] ALU_NEQ = ALU_W'(4'h9);
    localparam logic [ALU_W-1:0] ALU_GE  = ALU_W'(4'hA);
    localparam logic [ALU_W-1:0] ALU_LTU = ALU_W'(4'hB);
    localparam logic [ALU_W-1:0] ALU_GEU = ALU_W'(4'hC);
    localparam logic [ALU_W-1:0] ALU_MUL = ALU_W'(4'hD);
    localparam logic [ALU_W-1:0] ALU_DIV = ALU_W'(4'hE);
    localparam logic [ALU_W-1:0] ALU_REM = ALU_W'(4'hF);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JALR, S_JAL,
        S_LUI, S_AUIPC, S_TRAP
    } state_e;

    state_e state_q, state_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    logic [ALU_W-1:0] alu_r, alu_i, alu_b;
    logic             legal_r, legal_i, legal_b;

    // Register-register operation decode
    always_comb begin
        alu_r   = ALU_ADD;
        legal_r = 1'b1;
        if (funct7 == 7'b0000000) begin
            case (funct3)
                3'b000:  alu_r = ALU_ADD;
                3'b001:  alu_r = ALU_SLL;
                3'b010:  alu_r = ALU_SLT;
                3'b011:  alu_r = ALU_LTU;
                3'b100:  alu_r = ALU_XOR;
                3'b110:  alu_r = ALU_OR;
                3'b111:  alu_r = ALU_AND;
                default: legal_r = 1'b0;   // SRL not supported
            endcase
        end else if (funct7 == 7'b0100000) begin
            case (funct3)
                3'b000:  alu_r = ALU_SUB;
                3'b101:  alu_r = ALU_SRA;
                default: legal_r = 1'b0;
            endcase
        end else if (M_EXT && (funct7 == 7'b0000001)) begin
            case (funct3)
                3'b000:  alu_r = ALU_MUL;
                3'b100:  alu_r = ALU_DIV;
                3'b110:  alu_r = ALU_REM;
                default: legal_r = 1'b0;
            endcase
        end else begin
            legal_r = 1'b0;
        end
    end

    // Register-immediate decode; funct7 only qualifies the shifts
    always_comb begin
        alu_i   = ALU_ADD;
        legal_i = 1'b1;
        case (funct3)
            3'b000: alu_i = ALU_ADD;
            3'b001: begin
                if (funct7 == 7'b0000000) alu_i = ALU_SLL;
                else                      legal_i = 1'b0;
            end
            3'b010: alu_i = ALU_SLT;
            3'b011: alu_i = ALU_LTU;
            3'b100: alu_i = ALU_XOR;
            3'b101: begin
                if (funct7 == 7'b0100000) alu_i = ALU_SRA;
                else                      legal_i = 1'b0;
            end
            3'b110: alu_i = ALU_OR;
            default: alu_i = ALU_AND;
        endcase
    end

    // Branch compare decode; ALU result 1 means taken
    always_comb begin
        alu_b   = ALU_ADD;
        legal_b = 1'b1;
        case (funct3)
            3'b000:  alu_b = ALU_EQ;
            3'b001:  alu_b = ALU_NEQ;
            3'b100:  alu_b = ALU_SLT;
            3'b101:  alu_b = ALU_GE;
            3'b110:  alu_b = ALU_LTU;
            3'b111:  alu_b = ALU_GEU;
            default: legal_b = 1'b0;
        endcase
    end

    // Immediate format follows the opcode in every state
    always_comb begin
        case (opcode)
            OP_STORE:         imm_src = 3'b001;
            OP_BRANCH:        imm_src = 3'b010;
            OP_LUI, OP_AUIPC: imm_src = 3'b011;
            OP_JAL:           imm_src = 3'b100;
            default:          imm_src = 3'b000;
        endcase
    end

    assign trap = (state_q == S_TRAP);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next state and datapath controls
    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_ctrl   = ALU_ADD;
        retire     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // old_pc + imm precomputes the branch/JAL target into ALUOut
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                    OP_REG:            state_d = S_EXEC_R;
                    OP_IMM:            state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_ctrl  = alu_r;
                state_d   = legal_r ? S_ALU_WB : S_TRAP;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_ctrl  = alu_i;
                state_d   = legal_i ? S_ALU_WB : S_TRAP;
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_ctrl  = alu_b;
                if (legal_b) begin
                    pc_write = !zero;
                    retire   = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_JALR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = S_JAL;
            end
            S_JAL: begin
                // Jump to target in ALUOut while computing the link value
                pc_write  = 1'b1;
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                state_d   = S_ALU_WB;
            end
            S_LUI: begin
                alu_src_a = 2'b11;
                alu_src_b = 2'b01;
                state_d   = S_ALU_WB;
            end
            S_AUIPC: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                state_d   = S_ALU_WB;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        // No side effects may escape while reset is held
        if (!rst_n) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
        end
    end

endmodule

// File: tb/tb_ctrl_fsm.sv
// Scoreboard bench for ctrl_fsm: a driver applies one directed vector per
// cycle and queues the hand-derived output pattern for both an M_EXT=1 and
// an M_EXT=0 instance; a monitor pops and compares on every falling edge.
module tb_ctrl_fsm;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] imm_src;
        logic [1:0] result_src;
        logic [3:0] alu_ctrl;
        logic       retire;
        logic       trap;
    } exp_t;

    typedef struct {
        exp_t  e1;
        exp_t  e0;
        string name;
    } item_t;

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_LW   = 32'h0080A283;
    localparam logic [31:0] I_SW   = 32'h0020A223;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_BNE  = 32'h00209463;
    localparam logic [31:0] I_LUI  = 32'h123450B7;
    localparam logic [31:0] I_DIV  = 32'h0220C1B3;
    localparam logic [31:0] I_SRLI = 32'h0010D093;
    localparam logic [31:0] I_JALR = 32'h000100E7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic       m1_req, m1_we, m1_adr, m1_irw, m1_pcw, m1_rw, m1_ret, m1_trap;
    logic [1:0] m1_a, m1_b, m1_res;
    logic [2:0] m1_imm;
    logic [3:0] m1_alu;
    logic       m0_req, m0_we, m0_adr, m0_irw, m0_pcw, m0_rw, m0_ret, m0_trap;
    logic [1:0] m0_a, m0_b, m0_res;
    logic [2:0] m0_imm;
    logic [3:0] m0_alu;

    ctrl_fsm #(.M_EXT(1'b1)) dut_m1 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(m1_req), .mem_we(m1_we), .adr_src(m1_adr), .ir_write(m1_irw),
        .pc_write(m1_pcw), .reg_write(m1_rw), .alu_src_a(m1_a), .alu_src_b(m1_b),
        .imm_src(m1_imm), .result_src(m1_res), .alu_ctrl(m1_alu), .retire(m1_ret),
        .trap(m1_trap)
    );

    ctrl_fsm #(.M_EXT(1'b0)) dut_m0 (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(m0_req), .mem_we(m0_we), .adr_src(m0_adr), .ir_write(m0_irw),
        .pc_write(m0_pcw), .reg_write(m0_rw), .alu_src_a(m0_a), .alu_src_b(m0_b),
        .imm_src(m0_imm), .result_src(m0_res), .alu_ctrl(m0_alu), .retire(m0_ret),
        .trap(m0_trap)
    );

    always #5 clk = ~clk;

    item_t q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Expected-pattern builders, one per control step
    function automatic exp_t base(input logic [31:0] ins);
        exp_t e = '0;
        case (ins[6:0])
            7'b0100011:             e.imm_src = 3'b001;
            7'b1100011:             e.imm_src = 3'b010;
            7'b0110111, 7'b0010111: e.imm_src = 3'b011;
            7'b1101111:             e.imm_src = 3'b100;
            default:                e.imm_src = 3'b000;
        endcase
        return e;
    endfunction

    function automatic exp_t f_rst(input logic [31:0] ins);
        exp_t e = base(ins);
        e.alu_src_b = 2'b10; e.result_src = 2'b10;
        return e;
    endfunction

    function automatic exp_t f_fetch(input logic [31:0] ins, input logic rdy);
        exp_t e = f_rst(ins);
        e.mem_req = 1'b1; e.ir_write = rdy; e.pc_write = rdy;
        return e;
    endfunction

    function automatic exp_t f_ab(input logic [31:0] ins, input logic [1:0] a,
                                  input logic [1:0] b, input logic [3:0] alu);
        exp_t e = base(ins);
        e.alu_src_a = a; e.alu_src_b = b; e.alu_ctrl = alu;
        return e;
    endfunction

    function automatic exp_t f_memrd(input logic [31:0] ins);
        exp_t e = base(ins);
        e.mem_req = 1'b1; e.adr_src = 1'b1;
        return e;
    endfunction

    function automatic exp_t f_memwr(input logic [31:0] ins, input logic rdy);
        exp_t e = f_memrd(ins);
        e.mem_we = 1'b1; e.retire = rdy;
        return e;
    endfunction

    function automatic exp_t f_wb(input logic [31:0] ins, input logic [1:0] res);
        exp_t e = base(ins);
        e.result_src = res; e.reg_write = 1'b1; e.retire = 1'b1;
        return e;
    endfunction

    function automatic exp_t f_branch(input logic [31:0] ins, input logic [3:0] alu,
                                      input logic z);
        exp_t e = f_ab(ins, 2'b10, 2'b00, alu);
        e.pc_write = !z; e.retire = 1'b1;
        return e;
    endfunction

    function automatic exp_t f_jal(input logic [31:0] ins);
        exp_t e = f_ab(ins, 2'b01, 2'b10, 4'h0);
        e.pc_write = 1'b1;
        return e;
    endfunction

    function automatic exp_t f_trap(input logic [31:0] ins);
        exp_t e = base(ins);
        e.trap = 1'b1;
        return e;
    endfunction

    task automatic step2(input logic r, input logic [31:0] ins, input logic z,
                         input logic rdy, input exp_t x1, input exp_t x0,
                         input string nm);
        item_t it;
        @(posedge clk);
        #1;
        rst_n = r; instr = ins; zero = z; mem_ready = rdy;
        it.e1 = x1; it.e0 = x0; it.name = nm;
        q.push_back(it);
    endtask

    task automatic st(input logic r, input logic [31:0] ins, input logic z,
                      input logic rdy, input exp_t x, input string nm);
        step2(r, ins, z, rdy, x, x, nm);
    endtask

    // Monitor: the control outputs are valid every cycle, so compare each one
    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            exp_t  a1, a0;
            it = q.pop_front();
            a1 = {m1_req, m1_we, m1_adr, m1_irw, m1_pcw, m1_rw, m1_a, m1_b,
                  m1_imm, m1_res, m1_alu, m1_ret, m1_trap};
            a0 = {m0_req, m0_we, m0_adr, m0_irw, m0_pcw, m0_rw, m0_a, m0_b,
                  m0_imm, m0_res, m0_alu, m0_ret, m0_trap};
            n_cmp = n_cmp + 2;
            if (a1 !== it.e1) begin
                n_bad = n_bad + 1;
                $display("FAIL %s mext1: got %b want %b", it.name, a1, it.e1);
            end
            if (a0 !== it.e0) begin
                n_bad = n_bad + 1;
                $display("FAIL %s mext0: got %b want %b", it.name, a0, it.e0);
            end
        end
    end

    initial begin
        // Reset state
        st(0, I_ADD, 0, 1, f_rst(I_ADD), "reset0");
        st(0, I_ADD, 0, 1, f_rst(I_ADD), "reset1");

        // ADD: four states, writeback only in the last
        st(1, I_ADD, 0, 1, f_fetch(I_ADD, 1), "add_fetch");
        st(1, I_ADD, 0, 1, f_ab(I_ADD, 2'b01, 2'b01, 4'h0), "add_decode");
        st(1, I_ADD, 0, 1, f_ab(I_ADD, 2'b10, 2'b00, 4'h0), "add_exec");
        st(1, I_ADD, 0, 1, f_wb(I_ADD, 2'b00), "add_wb");

        // LW with three wait states in FETCH and in MEM_RD
        for (int i = 0; i < 3; i++) st(1, I_LW, 0, 0, f_fetch(I_LW, 0), "lw_fetch_wait");
        st(1, I_LW, 0, 1, f_fetch(I_LW, 1), "lw_fetch");
        st(1, I_LW, 0, 1, f_ab(I_LW, 2'b01, 2'b01, 4'h0), "lw_decode");
        st(1, I_LW, 0, 1, f_ab(I_LW, 2'b10, 2'b01, 4'h0), "lw_memadr");
        for (int i = 0; i < 3; i++) st(1, I_LW, 0, 0, f_memrd(I_LW), "lw_memrd_wait");
        st(1, I_LW, 0, 1, f_memrd(I_LW), "lw_memrd");
        st(1, I_LW, 0, 0, f_wb(I_LW, 2'b01), "lw_memwb");

        // SW with one wait state before completion
        st(1, I_SW, 0, 1, f_fetch(I_SW, 1), "sw_fetch");
        st(1, I_SW, 0, 1, f_ab(I_SW, 2'b01, 2'b01, 4'h0), "sw_decode");
        st(1, I_SW, 0, 1, f_ab(I_SW, 2'b10, 2'b01, 4'h0), "sw_memadr");
        st(1, I_SW, 0, 0, f_memwr(I_SW, 0), "sw_memwr_wait");
        st(1, I_SW, 0, 1, f_memwr(I_SW, 1), "sw_memwr");

        // BEQ not taken, BNE taken
        st(1, I_BEQ, 0, 1, f_fetch(I_BEQ, 1), "beq_fetch");
        st(1, I_BEQ, 0, 1, f_ab(I_BEQ, 2'b01, 2'b01, 4'h0), "beq_decode");
        st(1, I_BEQ, 1, 1, f_branch(I_BEQ, 4'b1000, 1), "beq_branch");
        st(1, I_BNE, 0, 1, f_fetch(I_BNE, 1), "bne_fetch");
        st(1, I_BNE, 0, 1, f_ab(I_BNE, 2'b01, 2'b01, 4'h0), "bne_decode");
        st(1, I_BNE, 0, 1, f_branch(I_BNE, 4'b1001, 0), "bne_branch");

        // LUI selects the constant-zero operand
        st(1, I_LUI, 0, 1, f_fetch(I_LUI, 1), "lui_fetch");
        st(1, I_LUI, 0, 1, f_ab(I_LUI, 2'b01, 2'b01, 4'h0), "lui_decode");
        st(1, I_LUI, 0, 1, f_ab(I_LUI, 2'b11, 2'b01, 4'h0), "lui_exec");
        st(1, I_LUI, 0, 1, f_wb(I_LUI, 2'b00), "lui_wb");

        // DIV: legal with M_EXT=1, traps with M_EXT=0 and stays trapped
        st(1, I_DIV, 0, 1, f_fetch(I_DIV, 1), "div_fetch");
        st(1, I_DIV, 0, 1, f_ab(I_DIV, 2'b01, 2'b01, 4'h0), "div_decode");
        step2(1, I_DIV, 0, 1, f_ab(I_DIV, 2'b10, 2'b00, 4'b1110),
              f_ab(I_DIV, 2'b10, 2'b00, 4'h0), "div_exec");
        step2(1, I_DIV, 0, 1, f_wb(I_DIV, 2'b00), f_trap(I_DIV), "div_wb");
        for (int i = 0; i < 2; i++)
            step2(1, I_DIV, 0, 0, f_fetch(I_DIV, 0), f_trap(I_DIV), "div_after");
        st(0, I_DIV, 0, 0, f_rst(I_DIV), "div_reset");

        // SRLI is illegal; trap holds until reset, fetch resumes afterwards
        st(1, I_SRLI, 0, 1, f_fetch(I_SRLI, 1), "srli_fetch");
        st(1, I_SRLI, 0, 1, f_ab(I_SRLI, 2'b01, 2'b01, 4'h0), "srli_decode");
        st(1, I_SRLI, 0, 1, f_ab(I_SRLI, 2'b10, 2'b01, 4'h0), "srli_exec");
        for (int i = 0; i < 3; i++) st(1, I_SRLI, 0, 1, f_trap(I_SRLI), "srli_trap");
        st(0, I_SRLI, 0, 1, f_rst(I_SRLI), "srli_reset");
        st(1, I_SRLI, 0, 0, f_fetch(I_SRLI, 0), "srli_refetch");

        // JALR full sequence, then reset while in JAL
        st(1, I_JALR, 0, 1, f_fetch(I_JALR, 1), "jalr_fetch");
        st(1, I_JALR, 0, 1, f_ab(I_JALR, 2'b01, 2'b01, 4'h0), "jalr_decode");
        st(1, I_JALR, 0, 1, f_ab(I_JALR, 2'b10, 2'b01, 4'h0), "jalr_target");
        st(1, I_JALR, 0, 1, f_jal(I_JALR), "jalr_jal");
        st(1, I_JALR, 0, 1, f_wb(I_JALR, 2'b00), "jalr_wb");
        st(1, I_JALR, 0, 1, f_fetch(I_JALR, 1), "jalr2_fetch");
        st(1, I_JALR, 0, 1, f_ab(I_JALR, 2'b01, 2'b01, 4'h0), "jalr2_decode");
        st(1, I_JALR, 0, 1, f_ab(I_JALR, 2'b10, 2'b01, 4'h0), "jalr2_target");
        st(0, I_JALR, 0, 1, f_rst(I_JALR), "jalr2_reset_in_jal");
        st(1, I_JALR, 0, 0, f_fetch(I_JALR, 0), "jalr2_refetch");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 8; i++) begin
            if (q.size() == 0) break;
            @(negedge clk);
        end
        #1;
        n_cmp = n_cmp + 1;
        if (q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
